// File: rtl/i2c_target_rsp.sv
// I2C target responder: fixed device address, pointer-addressed byte register file.
// Oversamples SCL/SDA on clk_i; drives SDA open-drain via sda_oe_o and never stretches SCL.
module i2c_target_rsp #(
  parameter int unsigned                      I2C_ADDR_WIDTH  = 7,
  parameter int unsigned                      I2C_DATA_WIDTH  = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0]        I2C_DEVICE_ADDR = 7'h22,
  parameter int unsigned                      MEM_DEPTH       = 16,
  localparam int unsigned                     PTR_W           = $clog2(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe_o,
  output logic                      busy_o,
  output logic                      wr_valid_o,
  output logic [PTR_W-1:0]          wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o
);

  localparam int unsigned CNT_W = $clog2(I2C_DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_BYTE = CNT_W'(I2C_DATA_WIDTH);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWr, StWrAck, StRd, StRdAck, StIgnore
  } state_e;

  state_e r_state, w_state_next;

  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;

  logic [I2C_DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]          r_cnt;
  logic [PTR_W-1:0]          r_ptr;
  logic                      r_rw;
  logic                      r_sda_oe;
  logic                      r_wr_valid;
  logic [PTR_W-1:0]          r_wr_addr;
  logic [I2C_DATA_WIDTH-1:0] r_wr_data;
  logic [I2C_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                      w_scl_rise, w_scl_fall, w_start, w_stop;
  logic                      w_sda;
  logic [I2C_DATA_WIDTH-1:0] w_byte;
  logic                      w_last_bit, w_ack_done, w_addr_match;
  logic                      w_busy;

  // Synchronizers idle high so reset release does not fake a bus event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  assign w_sda        = r_sda_s2;
  assign w_scl_rise   = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_h;
  assign w_start      = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop       = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte       = {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
  assign w_last_bit   = (r_cnt == LAST_BIT);
  assign w_ack_done   = (r_cnt != '0);
  assign w_addr_match = (w_byte[I2C_DATA_WIDTH-1:1] == I2C_DEVICE_ADDR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = StAddr;
    end else if (w_stop) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StAddr:    if (w_scl_rise && w_last_bit) w_state_next = w_addr_match ? StAddrAck : StIgnore;
        StAddrAck: if (w_scl_fall && w_ack_done) w_state_next = r_rw ? StRd : StPtr;
        StPtr:     if (w_scl_rise && w_last_bit) w_state_next = StPtrAck;
        StPtrAck:  if (w_scl_fall && w_ack_done) w_state_next = StWr;
        StWr:      if (w_scl_rise && w_last_bit) w_state_next = StWrAck;
        StWrAck:   if (w_scl_fall && w_ack_done) w_state_next = StWr;
        StRd:      if (w_scl_fall && r_cnt == FULL_BYTE) w_state_next = StRdAck;
        StRdAck: begin
          if (w_scl_rise && w_sda) begin
            w_state_next = StIgnore;
          end else if (w_scl_fall && w_ack_done) begin
            w_state_next = StRd;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b1;
    unique case (r_state)
      StIdle, StAddr, StIgnore: w_busy = 1'b0;
      default: ;
    endcase
  end

  // In ACK states r_cnt is 0 until the 9th rising edge, then marks "ACK clocked out".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
      end else begin
        unique case (r_state)
          StAddr, StPtr, StWr: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
              if (w_last_bit) begin
                if (r_state == StAddr) r_rw <= w_byte[0];
                if (r_state == StPtr) r_ptr <= w_byte[PTR_W-1:0];
                if (r_state == StWr) begin
                  r_mem[r_ptr] <= w_byte;
                  r_wr_valid   <= 1'b1;
                  r_wr_addr    <= r_ptr;
                  r_wr_data    <= w_byte;
                  r_ptr        <= r_ptr + PTR_W'(1);
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWrAck: begin
            if (w_scl_rise) r_cnt <= CNT_W'(1);
            if (w_scl_fall) begin
              if (!w_ack_done) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_cnt <= '0;
                if (r_state == StAddrAck && r_rw) begin
                  r_shift  <= r_mem[r_ptr];
                  r_sda_oe <= ~r_mem[r_ptr][I2C_DATA_WIDTH-1];
                end else begin
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          StRd: begin
            if (w_scl_rise) r_cnt <= r_cnt + CNT_W'(1);
            if (w_scl_fall) begin
              if (r_cnt == FULL_BYTE) begin
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
              end else begin
                r_shift  <= r_shift << 1;
                r_sda_oe <= ~r_shift[I2C_DATA_WIDTH-2];
              end
            end
          end
          StRdAck: begin
            if (w_scl_rise && !w_sda) begin
              r_cnt <= CNT_W'(1);
              r_ptr <= r_ptr + PTR_W'(1);
            end
            if (w_scl_fall && w_ack_done) begin
              r_cnt    <= '0;
              r_shift  <= r_mem[r_ptr];
              r_sda_oe <= ~r_mem[r_ptr][I2C_DATA_WIDTH-1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o   = r_sda_oe;
  assign busy_o     = w_busy;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;

endmodule

// File: doc/i2c_target_rsp.md
# i2c_target_rsp

Synthesizable I2C target (slave) responder for the other end of the bus driven by the iicmb Wishbone-to-I2C controller. It decodes START/STOP, matches a fixed 7-bit device address, ACKs, and serves a pointer-addressed byte register file for writes and reads. It is the RTL counterpart of the bench's I2C slave BFM: it runs in closed loop against the DUT and can stand in as a real target in the same top.

## Interface
- I2C_ADDR_WIDTH, 7, device address width
- I2C_DATA_WIDTH, 8, byte width
- I2C_DEVICE_ADDR, 7'h22, address this target answers to
- MEM_DEPTH, 16, register file depth; power of two; PTR_W = $clog2(MEM_DEPTH)

Ports:
- clk_i  in  1  system clock; single clock domain
- rst_n_i  in  1  reset, asynchronous, active-low
- scl_i  in  1  I2C clock, sampled (asynchronous to clk_i)
- sda_i  in  1  I2C data, sampled (asynchronous to clk_i)
- sda_oe_o  out  1  1 = pull SDA low (open drain); 0 = release
- busy_o  out  1  high from matched address ACK until STOP, repeated START, or NACK/mismatch
- wr_valid_o  out  1  one-cycle pulse per data byte stored
- wr_addr_o  out  PTR_W  register index of stored byte
- wr_data_o  out  8  stored byte

## Operation
- scl_i/sda_i pass through 2-flop synchronizers plus one history flop. Edges are detected on synchronized values.
- START / repeated START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both events are honoured in every state.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- IDLE --START--> ADDR. ADDR shifts 8 bits MSB-first on SCL rising edges: 7 address bits + R/W.
- Address match -> ADDR_ACK. Mismatch -> IGNORE; SDA stays released, so the master sees a NACK.
- ADDR_ACK: drive ACK for the 9th bit.
  - W: go to PTR.
  - R: go to RD and load shift register with mem[ptr].
- PTR: the first write byte sets ptr = byte[PTR_W-1:0]; upper bits are ignored. ACK, then WR.
- WR: each received byte is written to mem[ptr]. wr_valid_o pulses with the pre-increment ptr. ACK, then ptr = ptr+1, wrapping mod MEM_DEPTH.
- RD: drive bits MSB-first; bit value 1 = release. After the 8th bit, release SDA and sample the master's ACK on the 9th SCL rising edge.
  - ACK (0): ptr++, load next byte, continue RD.
  - NACK (1): IGNORE.
- IGNORE: SDA released; wait for STOP (-> IDLE) or START (-> ADDR).
- Repeated START in any state -> ADDR. ptr is retained, so W-ptr / Sr / R reads from the pointer just set.
- STOP in any state -> IDLE; ptr is retained.
- The target always ACKs writes; there is no full condition. No clock stretching: SCL is never driven.

## Timing
- Reset (rst_n_i low, asynchronous):
  - sda_oe_o=0, busy_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0
  - state=IDLE, ptr=0, all mem entries 0, synchronizers reset to 1
- Reset asserted mid-transfer releases SDA immediately, without waiting for a clock edge.
- Detection latency: 3 clk_i cycles from pin change to edge/event.
- clk_i must be ≥ 16× SCL frequency.
- SDA updates only on detected SCL falling edges:
  - ACK asserted on the falling edge after bit 8; released on the falling edge after bit 9.
  - Read data bit n driven on the falling edge preceding SCL high of bit n. The first read bit is driven on the falling edge ending the address ACK.
- Data bits are sampled on detected SCL rising edges.
- wr_valid_o pulses the cycle after the 8th data bit's rising edge is detected. wr_addr_o/wr_data_o hold until the next pulse.
- busy_o rises with ADDR_ACK entry and falls on the cycle STOP, Sr, mismatch, or read-NACK is detected.
- If START and a SCL edge are detected in the same cycle, START wins.

## Test plan
- Write: START, 0x44 (0x22+W), 0x05, 0x44, 0x78, STOP -> ACK on all four bytes. wr_valid_o pulses with (5,0x44) then (6,0x78). mem[5]=0x44, mem[6]=0x78. busy_o low after STOP.
- Combined read: START, 0x44, 0x05, Sr, 0x45, read two bytes with ACK then NACK, STOP -> bytes 0x44, 0x78 on SDA. sda_oe_o=0 during the master's ACK/NACK bits and after the NACK.
- Mismatch: START, 0x46 (0x23+W), 0x11, STOP -> no ACK on any bit, no wr_valid_o, busy_o stays 0, mem unchanged.
- Wrap: write pointer 0x0F, data 0xAA, 0xBB -> mem[15]=0xAA, mem[0]=0xBB, wr_addr_o 15 then 0. Pointer byte 0x35 with MEM_DEPTH=16 selects index 5.
- Reset mid-read: assert rst_n_i while the target drives a 0 data bit -> sda_oe_o=0 within the same timestep. Then START, 0x45 -> ACK, first byte 0x00 (mem cleared, ptr=0).
- Events in the middle of a byte: STOP after 4 data bits -> IDLE, no write. START after 3 address bits -> ADDR restarts and the next full 0x44 is ACKed.
